// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: INIT sweep after reset, then valid/ready
// arbitration between the ALU/EX (0) and MEM/load (1) writeback requesters.
module regfile_write_arbiter #(
  parameter int unsigned            DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE    = '0,
  parameter bit                     PRIORITY_MODE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_spec,
  input  logic [2:0]            req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_spec,
  input  logic [2:0]            req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rf_regWrite,
  output logic [1:0]            rf_writeSpecReg,
  output logic [2:0]            rf_R3,
  output logic [DATA_WIDTH-1:0] rf_inData3,
  output logic                  init_done,
  output logic                  grant_id
);

  localparam int unsigned SPEC_W   = 2;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] NUM_GP   = CNT_W'(8);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(10);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rr_q, rr_d;

  logic                    win0, win1;
  logic                    wr_en;
  logic                    wr_id;
  logic [SPEC_W-1:0]       wr_spec;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  // State register: INIT counter and round-robin pointer (req0 wins first tie)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state: step through the 11 INIT targets, track last winner in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (wr_en) begin
          rr_d = wr_id;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Output decode: INIT target generation or arbitration and winner mux
  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    wr_en   = 1'b0;
    wr_id   = 1'b0;
    wr_spec = '0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_data = INIT_VALUE;
        if (cnt_q < NUM_GP) begin
          wr_addr = cnt_q[ADDR_W-1:0];
        end else begin
          // cnt 8/9/10 map to SP/IH/T
          wr_spec = SPEC_W'(cnt_q - CNT_W'(7));
        end
      end
      S_RUN: begin
        // rr_q names the last winner; the other requester wins a tie
        if (req0_valid && (!req1_valid || PRIORITY_MODE || rr_q)) begin
          win0 = 1'b1;
        end else if (req1_valid) begin
          win1 = 1'b1;
        end
        wr_en = win0 | win1;
        wr_id = win1;
        if (win1) begin
          wr_spec = req1_spec;
          wr_addr = req1_addr;
          wr_data = req1_data;
        end else begin
          wr_spec = req0_spec;
          wr_addr = req0_addr;
          wr_data = req0_data;
        end
        if (wr_spec != 2'b00) begin
          wr_addr = '0;
        end
      end
      default: ;
    endcase
  end

  assign req0_ready = win0;
  assign req1_ready = win1;

  // Register-file drive: strobe every cycle, payload holds when idle
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_regWrite     <= 1'b0;
      rf_writeSpecReg <= '0;
      rf_R3           <= '0;
      rf_inData3      <= '0;
      init_done       <= 1'b0;
      grant_id        <= 1'b0;
    end else begin
      rf_regWrite <= wr_en;
      init_done   <= (state_q == S_RUN);
      if (wr_en) begin
        rf_writeSpecReg <= wr_spec;
        rf_R3           <= wr_addr;
        rf_inData3      <= wr_data;
      end
      if (wr_en && (state_q == S_RUN)) begin
        grant_id <= wr_id;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: one round-robin and one fixed-priority
// instance share stimulus; expected writes are queued per instance and
// matched against every observed rf_regWrite pulse.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_spec, req1_spec;
  logic [2:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;

  logic        req0_ready_rr, req1_ready_rr, rf_regWrite_rr, init_done_rr, grant_id_rr;
  logic [1:0]  rf_spec_rr;
  logic [2:0]  rf_R3_rr;
  logic [15:0] rf_data_rr;

  logic        req0_ready_fp, req1_ready_fp, rf_regWrite_fp, init_done_fp, grant_id_fp;
  logic [1:0]  rf_spec_fp;
  logic [2:0]  rf_R3_fp;
  logic [15:0] rf_data_fp;

  typedef struct packed {
    logic [1:0]  spec;
    logic [2:0]  r3;
    logic [15:0] data;
    logic        gid;
  } exp_t;

  exp_t exp_rr[$];
  exp_t exp_fp[$];

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH(16), .INIT_VALUE(16'h0000), .PRIORITY_MODE(1'b0)
  ) dut_rr (
    .CLK(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_rr), .req0_spec(req0_spec),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready_rr), .req1_spec(req1_spec),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_regWrite(rf_regWrite_rr), .rf_writeSpecReg(rf_spec_rr), .rf_R3(rf_R3_rr),
    .rf_inData3(rf_data_rr), .init_done(init_done_rr), .grant_id(grant_id_rr)
  );

  regfile_write_arbiter #(
    .DATA_WIDTH(16), .INIT_VALUE(16'h0000), .PRIORITY_MODE(1'b1)
  ) dut_fp (
    .CLK(clk), .RST(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_fp), .req0_spec(req0_spec),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready_fp), .req1_spec(req1_spec),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_regWrite(rf_regWrite_fp), .rf_writeSpecReg(rf_spec_fp), .rf_R3(rf_R3_fp),
    .rf_inData3(rf_data_fp), .init_done(init_done_fp), .grant_id(grant_id_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the round-robin instance
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rf_regWrite_rr === 1'b1) begin
      checks++;
      if (exp_rr.size() == 0) begin
        errors++;
        $display("FAIL rr_write: got spec=%b r3=%0d data=%h gid=%b, required no write",
                 rf_spec_rr, rf_R3_rr, rf_data_rr, grant_id_rr);
      end else begin
        e = exp_rr.pop_front();
        if ({rf_spec_rr, rf_R3_rr, rf_data_rr, grant_id_rr} !== e) begin
          errors++;
          $display("FAIL rr_write: got spec=%b r3=%0d data=%h gid=%b, required spec=%b r3=%0d data=%h gid=%b",
                   rf_spec_rr, rf_R3_rr, rf_data_rr, grant_id_rr, e.spec, e.r3, e.data, e.gid);
        end
      end
    end
  end

  // Scoreboard for the fixed-priority instance
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rf_regWrite_fp === 1'b1) begin
      checks++;
      if (exp_fp.size() == 0) begin
        errors++;
        $display("FAIL fp_write: got spec=%b r3=%0d data=%h gid=%b, required no write",
                 rf_spec_fp, rf_R3_fp, rf_data_fp, grant_id_fp);
      end else begin
        e = exp_fp.pop_front();
        if ({rf_spec_fp, rf_R3_fp, rf_data_fp, grant_id_fp} !== e) begin
          errors++;
          $display("FAIL fp_write: got spec=%b r3=%0d data=%h gid=%b, required spec=%b r3=%0d data=%h gid=%b",
                   rf_spec_fp, rf_R3_fp, rf_data_fp, grant_id_fp, e.spec, e.r3, e.data, e.gid);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [1:0] s, input logic [2:0] a,
                              input logic [15:0] d, input logic g);
    exp_t e;
    e.spec = s; e.r3 = a; e.data = d; e.gid = g;
    return e;
  endfunction

  task automatic drain_check(input string name);
    checks++;
    if (exp_rr.size() != 0 || exp_fp.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: got rr=%0d fp=%0d pending, required 0",
               name, exp_rr.size(), exp_fp.size());
      exp_rr.delete();
      exp_fp.delete();
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_spec = 2'b00; req1_spec = 2'b00;
    req0_addr = 3'd0;  req1_addr = 3'd0;
    req0_data = 16'h0; req1_data = 16'h0;
  endtask

  // Releases reset (already applied) and checks the full 11-write INIT sweep
  task automatic run_init_seq(input string name);
    for (int i = 0; i < 11; i++) begin
      logic [1:0] s;
      logic [2:0] a;
      s = (i < 8) ? 2'b00 : 2'(i - 7);
      a = (i < 8) ? 3'(i) : 3'd0;
      exp_rr.push_back(mk(s, a, 16'h0000, 1'b0));
      exp_fp.push_back(mk(s, a, 16'h0000, 1'b0));
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 16'hFFFF; req0_addr = 3'd6;
    req1_valid = 1'b1; req1_data = 16'hEEEE; req1_addr = 3'd7;
    for (int i = 0; i < 11; i++) begin
      #1;
      checks++;
      if ({req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp} !== 4'b0000) begin
        errors++;
        $display("FAIL %s_ready_in_init: cycle %0d got %b%b%b%b, required 0000", name, i,
                 req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp);
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if ({init_done_rr, init_done_fp} !== 2'b00) begin
      errors++;
      $display("FAIL %s_init_done_early: got %b%b, required 00", name, init_done_rr, init_done_fp);
    end
    @(negedge clk);
    checks++;
    if ({init_done_rr, init_done_fp} !== 2'b11) begin
      errors++;
      $display("FAIL %s_init_done: got %b%b, required 11", name, init_done_rr, init_done_fp);
    end
    drain_check(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({rf_regWrite_rr, rf_spec_rr, rf_R3_rr, rf_data_rr, init_done_rr, grant_id_rr} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rr: got we=%b spec=%b r3=%0d data=%h done=%b gid=%b, required all 0",
               rf_regWrite_rr, rf_spec_rr, rf_R3_rr, rf_data_rr, init_done_rr, grant_id_rr);
    end
    checks++;
    if ({rf_regWrite_fp, rf_spec_fp, rf_R3_fp, rf_data_fp, init_done_fp, grant_id_fp} !== 24'h0) begin
      errors++;
      $display("FAIL reset_fp: got we=%b spec=%b r3=%0d data=%h done=%b gid=%b, required all 0",
               rf_regWrite_fp, rf_spec_fp, rf_R3_fp, rf_data_fp, init_done_fp, grant_id_fp);
    end
    run_init_seq("init");
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_spec = 2'b00; req0_addr = 3'd5; req0_data = 16'hBEEF;
    exp_rr.push_back(mk(2'b00, 3'd5, 16'hBEEF, 1'b0));
    exp_fp.push_back(mk(2'b00, 3'd5, 16'hBEEF, 1'b0));
    #1;
    checks++;
    if ({req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp} !== 4'b1010) begin
      errors++;
      $display("FAIL single_ready: got %b%b%b%b, required 1010",
               req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp);
    end
    @(negedge clk);
    idle_inputs();
    drain_check("single");
    @(negedge clk);
    checks++;
    if ({rf_regWrite_rr, rf_R3_rr, rf_data_rr, grant_id_rr} !== {1'b0, 3'd5, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: got we=%b r3=%0d data=%h gid=%b, required we=0 r3=5 data=beef gid=0",
               rf_regWrite_rr, rf_R3_rr, rf_data_rr, grant_id_rr);
    end
  endtask

  task automatic test_spec_target();
    req1_valid = 1'b1; req1_spec = 2'b10; req1_addr = 3'b111; req1_data = 16'h1234;
    exp_rr.push_back(mk(2'b10, 3'd0, 16'h1234, 1'b1));
    exp_fp.push_back(mk(2'b10, 3'd0, 16'h1234, 1'b1));
    #1;
    checks++;
    if ({req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp} !== 4'b0101) begin
      errors++;
      $display("FAIL spec_ready: got %b%b%b%b, required 0101",
               req0_ready_rr, req1_ready_rr, req0_ready_fp, req1_ready_fp);
    end
    @(negedge clk);
    idle_inputs();
    drain_check("spec");
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_spec = 2'b00; req0_addr = 3'd1; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_spec = 2'b00; req1_addr = 3'd2; req1_data = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = (k % 2) == 1;
      if (g) exp_rr.push_back(mk(2'b00, 3'd2, 16'h0002, 1'b1));
      else   exp_rr.push_back(mk(2'b00, 3'd1, 16'h0001, 1'b0));
      exp_fp.push_back(mk(2'b00, 3'd1, 16'h0001, 1'b0));
      #1;
      checks++;
      if ({req0_ready_rr, req1_ready_rr} !== {~g, g}) begin
        errors++;
        $display("FAIL rr_alternate: cycle %0d got %b%b, required %b%b", k,
                 req0_ready_rr, req1_ready_rr, ~g, g);
      end
      checks++;
      if ({req0_ready_fp, req1_ready_fp} !== 2'b10) begin
        errors++;
        $display("FAIL fp_tie: cycle %0d got %b%b, required 10", k, req0_ready_fp, req1_ready_fp);
      end
      @(negedge clk);
    end
    idle_inputs();
    drain_check("b2b");
  endtask

  task automatic test_priority();
    req0_valid = 1'b1; req0_spec = 2'b00; req0_addr = 3'd3; req0_data = 16'h00A0;
    req1_valid = 1'b1; req1_spec = 2'b00; req1_addr = 3'd4; req1_data = 16'h00B1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req0_valid = 1'b0;
      if (k == 1 || k == 3) exp_rr.push_back(mk(2'b00, 3'd4, 16'h00B1, 1'b1));
      else                  exp_rr.push_back(mk(2'b00, 3'd3, 16'h00A0, 1'b0));
      if (k == 3) exp_fp.push_back(mk(2'b00, 3'd4, 16'h00B1, 1'b1));
      else        exp_fp.push_back(mk(2'b00, 3'd3, 16'h00A0, 1'b0));
      #1;
      checks++;
      if ({req0_ready_fp, req1_ready_fp} !== ((k == 3) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL priority_ready: cycle %0d got %b%b, required %s", k,
                 req0_ready_fp, req1_ready_fp, (k == 3) ? "01" : "10");
      end
      @(negedge clk);
    end
    idle_inputs();
    drain_check("priority");
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    req0_valid = 1'b1; req0_spec = 2'b00; req0_addr = 3'd2; req0_data = 16'h5555;
    @(negedge clk);
    checks++;
    if ({rf_regWrite_rr, init_done_rr, grant_id_rr, rf_regWrite_fp, init_done_fp, grant_id_fp} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got rr we/done/gid=%b%b%b fp=%b%b%b, required 000 000",
               rf_regWrite_rr, init_done_rr, grant_id_rr, rf_regWrite_fp, init_done_fp, grant_id_fp);
    end
    run_init_seq("reinit");
  endtask

  initial begin
    test_reset();
    test_single();
    test_spec_target();
    test_back_to_back();
    test_priority();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    drain_check("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
